nand_sweep_checker: RTL
=======================

// Module: nand_sweep_checker
// PURPOSE
//  Self-checking exhaustive tester for an N-input NAND gate under test (GUT).
//  - Drives every input combination 0..2^N-1 onto test_vec.
//  - Waits SETTLE cycles for each vector, then compares dut_y with ~&test_vec.
//  - Counts mismatches and reports pass/fail.
//  - Sits beside a structural (switch-level) NAND in a bench or on-board self-test wrapper.
// PARAMETERS
//  N       2   GUT input count; sweep length 2^N vectors (N >= 1)
//  SETTLE  2   cycles each vector is held before sampling dut_y (>= 1)
//  ERR_W   8   width of the saturating error counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      pulse: begin sweep; sampled only in IDLE
//  abort      in   1      stop sweep, return to IDLE, no done pulse
//  dut_y      in   1      GUT output
//  test_vec   out  N      vector driven to GUT inputs
//  busy       out  1      high from start acceptance until done
//  done       out  1      one-cycle pulse at end of sweep
//  pass       out  1      err_cnt==0 at last completed sweep; held until next start
//  err_cnt    out  ERR_W  mismatch count, saturates at 2^ERR_W-1
// BEHAVIOUR
//  Reset (rst=1 at posedge, any state):
//   - state=IDLE, test_vec=0, busy=0, done=0, pass=0, err_cnt=0, settle counter=0.
//   - Reset mid-sweep discards all progress.
//  FSM states and transitions:
//   - IDLE:  start=1 -> test_vec=0, err_cnt=0, pass=0, settle_cnt=0, busy=1, go DRIVE.
//   - DRIVE: test_vec held; settle_cnt++. At settle_cnt==SETTLE-1 -> CHECK.
//   - CHECK: sample dut_y once; if dut_y != ~&test_vec, err_cnt++ (saturating).
//            If test_vec==all-ones -> DONE; else test_vec++, settle_cnt=0, go DRIVE.
//   - DONE:  done=1 for exactly one cycle; pass=(err_cnt==0); busy=0; go IDLE.
//  Timing and latency:
//   - All outputs are registered.
//   - Each vector occupies SETTLE+1 cycles.
//   - done is high in the cycle 2^N*(SETTLE+1) clocks after the edge that sampled start.
//  Handshake:
//   - start is ignored while busy=1.
//   - start in the DONE cycle is ignored.
//   - start is level-tolerant: a held start re-triggers only from IDLE.
//  abort (any non-IDLE state):
//   - Next state IDLE, busy=0, no done pulse, pass=0.
//   - err_cnt and test_vec keep their values.
//   - rst has priority over abort; abort has priority over start.
//  Width and boundary rules:
//   - test_vec is never incremented past all-ones; no wrap to 0 inside a sweep.
//   - err_cnt stops at 2^ERR_W-1. A saturated count still gives pass=0.
//   - N=1: sweep is vectors 0,1 only.
// CONFIGURATION
//  NANDCHK_FIRST_FAIL_EN
//   - Defined: adds outputs first_fail_vec [N] and first_fail_vld [1].
//     - On the first mismatch of a sweep, capture test_vec and set vld=1.
//     - Later mismatches do not overwrite the capture.
//     - Both are cleared by rst and on start acceptance.
//   - Undefined: these ports and their registers do not exist.
//     All other behaviour is identical.
// TESTING
//  1. N=2, SETTLE=2, ideal GUT (dut_y=~&test_vec), start pulse
//     -> done 12 clks later, pass=1, err_cnt=0, busy low after done.
//  2. N=2, GUT stuck-at-0 -> err_cnt=3, pass=0.
//     FIRST_FAIL_EN: first_fail_vec=2'b00.
//  3. N=2, GUT stuck-at-1 -> err_cnt=1, pass=0.
//     FIRST_FAIL_EN: first_fail_vec=2'b11, first_fail_vld=1.
//  4. N=4, ERR_W=2, GUT=AND (inverted) -> 16 mismatches, err_cnt saturates at 3, pass=0.
//  5. Start re-pulsed mid-sweep -> ignored, done timing unchanged.
//     abort at vector 2 -> IDLE next cycle, no done, busy=0.
//  6. rst asserted mid-sweep -> all outputs at reset values next cycle.
//     Fresh start -> full sweep, same result as scenario 1.

Source files
------------

// File: rtl/nand_sweep_checker.sv
// Exhaustive sweep checker for an N-input NAND gate under test.
// Optional first-failure capture: define NANDCHK_FIRST_FAIL_EN.
module nand_sweep_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_y,
  output logic [N-1:0]     test_vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef NANDCHK_FIRST_FAIL_EN
  ,
  output logic [N-1:0]     first_fail_vec,
  output logic             first_fail_vld
`endif
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    settle_cnt, settle_nxt;
  logic [N-1:0]     vec_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             mismatch;

`ifdef NANDCHK_FIRST_FAIL_EN
  logic [N-1:0]     ff_vec_nxt;
  logic             ff_vld_nxt;
`endif

  assign mismatch = (dut_y != ~&test_vec);

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    vec_nxt    = test_vec;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    pass_nxt   = pass;
    err_nxt    = err_cnt;
`ifdef NANDCHK_FIRST_FAIL_EN
    ff_vec_nxt = first_fail_vec;
    ff_vld_nxt = first_fail_vld;
`endif
    // abort freezes vector and count so the failing point stays visible
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      pass_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nxt  = DRIVE;
            settle_nxt = '0;
            vec_nxt    = '0;
            err_nxt    = '0;
            pass_nxt   = 1'b0;
            busy_nxt   = 1'b1;
`ifdef NANDCHK_FIRST_FAIL_EN
            ff_vec_nxt = '0;
            ff_vld_nxt = 1'b0;
`endif
          end
        end
        DRIVE: begin
          if (settle_cnt == S_LAST) begin
            state_nxt = CHECK;
          end else begin
            settle_nxt = settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != '1) begin
              err_nxt = err_cnt + 1'b1;
            end
`ifdef NANDCHK_FIRST_FAIL_EN
            if (!first_fail_vld) begin
              ff_vec_nxt = test_vec;
              ff_vld_nxt = 1'b1;
            end
`endif
          end
          if (&test_vec) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            pass_nxt  = (err_nxt == '0);
          end else begin
            state_nxt  = DRIVE;
            vec_nxt    = test_vec + 1'b1;
            settle_nxt = '0;
          end
        end
        DONE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      test_vec   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
`ifdef NANDCHK_FIRST_FAIL_EN
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      test_vec   <= vec_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_cnt    <= err_nxt;
`ifdef NANDCHK_FIRST_FAIL_EN
      first_fail_vec <= ff_vec_nxt;
      first_fail_vld <= ff_vld_nxt;
`endif
    end
  end

endmodule
